// File: rtl/ex_stage_pkg.sv
// Shared types for the execute stage: opcodes, FSM states and the EX/MEM register layout.
package ex_stage_pkg;

  typedef enum logic [5:0] {
    OP_ADD  = 6'd0,  OP_ADDI = 6'd1,
    OP_SUB  = 6'd2,  OP_SUBI = 6'd3,
    OP_MUL  = 6'd4,  OP_MULI = 6'd5,
    OP_OR   = 6'd6,  OP_ORI  = 6'd7,
    OP_AND  = 6'd8,  OP_ANDI = 6'd9,
    OP_XOR  = 6'd10, OP_XORI = 6'd11,
    OP_LDW  = 6'd12, OP_STW  = 6'd13,
    OP_BZ   = 6'd14, OP_BEQ  = 6'd15,
    OP_JR   = 6'd16, OP_HALT = 6'd17
  } opcode_t;

  typedef enum logic [1:0] {IDLE, MUL, HALTED} ex_state_t;

  typedef struct packed {
    logic [31:0] alu_result;
    logic [31:0] store_data;
    logic [4:0]  rd_add;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        halt;
  } ex_mem_t;

  function automatic logic is_mul(input logic [5:0] op);
    return (op == OP_MUL) || (op == OP_MULI);
  endfunction

endpackage

// File: rtl/ex_stage_if.sv
// Decode-to-execute inputs and execute-to-memory/fetch outputs as one bundle.
interface ex_stage_if;
  logic [5:0]  opcode_f_id;
  logic [31:0] rs_reg_value_f_id;
  logic [31:0] rt_reg_value_f_id;
  logic [4:0]  rd_add_value_f_id;
  logic [31:0] i_data_f_id;
  logic [31:0] pc_in_f_id;
  logic [31:0] pc4_in_f_id;
  logic        branch_f_id;
  logic        mem_read_f_id;
  logic        mem_to_reg_f_id;
  logic        mem_write_f_id;
  logic        stall_2_id;
  logic [31:0] alu_result_2_mem;
  logic [31:0] store_data_2_mem;
  logic [4:0]  rd_add_2_mem;
  logic        reg_write_2_mem;
  logic        mem_read_2_mem;
  logic        mem_write_2_mem;
  logic        mem_to_reg_2_mem;
  logic        branch_taken_2_if;
  logic [31:0] branch_target_2_if;
  logic        halt_2_mem;

  modport master (
    output opcode_f_id, rs_reg_value_f_id, rt_reg_value_f_id, rd_add_value_f_id,
           i_data_f_id, pc_in_f_id, pc4_in_f_id, branch_f_id, mem_read_f_id,
           mem_to_reg_f_id, mem_write_f_id,
    input  stall_2_id, alu_result_2_mem, store_data_2_mem, rd_add_2_mem,
           reg_write_2_mem, mem_read_2_mem, mem_write_2_mem, mem_to_reg_2_mem,
           branch_taken_2_if, branch_target_2_if, halt_2_mem
  );

  modport slave (
    input  opcode_f_id, rs_reg_value_f_id, rt_reg_value_f_id, rd_add_value_f_id,
           i_data_f_id, pc_in_f_id, pc4_in_f_id, branch_f_id, mem_read_f_id,
           mem_to_reg_f_id, mem_write_f_id,
    output stall_2_id, alu_result_2_mem, store_data_2_mem, rd_add_2_mem,
           reg_write_2_mem, mem_read_2_mem, mem_write_2_mem, mem_to_reg_2_mem,
           branch_taken_2_if, branch_target_2_if, halt_2_mem
  );
endinterface

// File: rtl/ex_stage_mul.sv
// Multi-cycle multiplier: latches operands and destination on start, counts down MUL_LAT-1.
// done pulses in the cnt==0 cycle; product is the low 32 bits of the latched operands.
module ex_mul #(
  parameter int MUL_LAT = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        active,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [4:0]  rd_in,
  output logic        cnt_zero,
  output logic        done,
  output logic [31:0] product,
  output logic [4:0]  rd_out
);

  logic [31:0] a_q, b_q;
  logic [4:0]  rd_q;
  logic [3:0]  cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q  <= '0;
      b_q  <= '0;
      rd_q <= '0;
      cnt  <= '0;
    end else if (start) begin
      a_q  <= a;
      b_q  <= b;
      rd_q <= rd_in;
      cnt  <= 4'(MUL_LAT - 1);
    end else if (active && cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end
  end

  assign cnt_zero = (cnt == 4'd0);
  assign done     = active && cnt_zero;
  assign product  = a_q * b_q;
  assign rd_out   = rd_q;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: ALU, branch resolution and multi-cycle multiply into the EX/MEM register.
// Single-cycle for non-multiply ops; stall_2_id holds decode while a multiply is busy.
module ex_stage #(
  parameter int MUL_LAT = 3
) (
  input logic     clk,
  input logic     reset,
  ex_stage_if.slave bus
);
  import ex_stage_pkg::*;

  ex_state_t   state_q, state_d;
  ex_mem_t     ex_mem_q, ex_mem_d;
  opcode_t     op;
  logic [31:0] op2, alu_val, target;
  logic        take, stall, mul_start;
  logic        mul_cnt_zero, mul_done;
  logic [31:0] mul_product;
  logic [4:0]  mul_rd;
  logic        unused_ok;

  assign op        = opcode_t'(bus.opcode_f_id);
  assign unused_ok = ^{bus.pc_in_f_id, bus.branch_f_id, mul_cnt_zero};

  ex_mul #(.MUL_LAT(MUL_LAT)) u_mul (
    .clk      (clk),
    .reset    (reset),
    .start    (mul_start),
    .active   (state_q == MUL),
    .a        (bus.rs_reg_value_f_id),
    .b        (op2),
    .rd_in    (bus.rd_add_value_f_id),
    .cnt_zero (mul_cnt_zero),
    .done     (mul_done),
    .product  (mul_product),
    .rd_out   (mul_rd)
  );

  // Odd ALU opcodes take the immediate as the second operand.
  always_comb begin
    op2     = bus.opcode_f_id[0] ? bus.i_data_f_id : bus.rt_reg_value_f_id;
    alu_val = '0;
    case (op)
      OP_ADD, OP_ADDI: alu_val = bus.rs_reg_value_f_id + op2;
      OP_SUB, OP_SUBI: alu_val = bus.rs_reg_value_f_id - op2;
      OP_OR,  OP_ORI:  alu_val = bus.rs_reg_value_f_id | op2;
      OP_AND, OP_ANDI: alu_val = bus.rs_reg_value_f_id & op2;
      OP_XOR, OP_XORI: alu_val = bus.rs_reg_value_f_id ^ op2;
      OP_LDW, OP_STW:  alu_val = bus.rs_reg_value_f_id + bus.i_data_f_id;
      default:         alu_val = '0;
    endcase
  end

  always_comb begin
    take   = 1'b0;
    target = '0;
    case (op)
      OP_BZ: begin
        take   = (bus.rs_reg_value_f_id == 32'd0);
        target = bus.pc4_in_f_id + (bus.i_data_f_id << 2);
      end
      OP_BEQ: begin
        take   = (bus.rs_reg_value_f_id == bus.rt_reg_value_f_id);
        target = bus.pc4_in_f_id + (bus.i_data_f_id << 2);
      end
      OP_JR: begin
        take   = 1'b1;
        target = bus.rs_reg_value_f_id;
      end
      default: ;
    endcase
    if (!take) target = '0;
  end

  always_comb begin
    state_d   = state_q;
    stall     = 1'b0;
    mul_start = 1'b0;
    ex_mem_d  = '0;
    case (state_q)
      IDLE: begin
        if (is_mul(bus.opcode_f_id)) begin
          stall     = 1'b1;
          mul_start = 1'b1;
          state_d   = MUL;
        end else if (op == OP_HALT) begin
          ex_mem_d.halt = 1'b1;
          state_d       = HALTED;
        end else if (bus.opcode_f_id <= 6'd13) begin
          ex_mem_d.alu_result = alu_val;
          ex_mem_d.rd_add     = bus.rd_add_value_f_id;
          ex_mem_d.reg_write  = (op != OP_STW) && (bus.rd_add_value_f_id != 5'd0);
          ex_mem_d.mem_read   = bus.mem_read_f_id;
          ex_mem_d.mem_write  = bus.mem_write_f_id;
          ex_mem_d.mem_to_reg = bus.mem_to_reg_f_id;
          if (op == OP_STW) ex_mem_d.store_data = bus.rt_reg_value_f_id;
        end else begin
          ex_mem_d.branch_taken  = take;
          ex_mem_d.branch_target = target;
        end
      end
      MUL: begin
        if (mul_done) begin
          ex_mem_d.alu_result = mul_product;
          ex_mem_d.rd_add     = mul_rd;
          ex_mem_d.reg_write  = (mul_rd != 5'd0);
          state_d             = IDLE;
        end else begin
          stall = 1'b1;
        end
      end
      HALTED:  state_d = HALTED;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      ex_mem_q <= '0;
    end else begin
      state_q  <= state_d;
      ex_mem_q <= ex_mem_d;
    end
  end

  // Stall is combinational from the inputs, so it must be forced low while in reset.
  assign bus.stall_2_id         = stall && !reset;
  assign bus.alu_result_2_mem   = ex_mem_q.alu_result;
  assign bus.store_data_2_mem   = ex_mem_q.store_data;
  assign bus.rd_add_2_mem       = ex_mem_q.rd_add;
  assign bus.reg_write_2_mem    = ex_mem_q.reg_write;
  assign bus.mem_read_2_mem     = ex_mem_q.mem_read;
  assign bus.mem_write_2_mem    = ex_mem_q.mem_write;
  assign bus.mem_to_reg_2_mem   = ex_mem_q.mem_to_reg;
  assign bus.branch_taken_2_if  = ex_mem_q.branch_taken;
  assign bus.branch_target_2_if = ex_mem_q.branch_target;
  assign bus.halt_2_mem         = ex_mem_q.halt;

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage with hand-computed expectations, MUL_LAT=3.
module tb_ex_stage;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   tests = 0;
  int   fails = 0;

  ex_stage_if bus();

  ex_stage #(.MUL_LAT(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [5:0] op, input logic [31:0] rs, input logic [31:0] rt,
                       input logic [31:0] imm, input logic [4:0] rd, input logic [31:0] pc4,
                       input logic mr, input logic mw, input logic mtr);
    bus.opcode_f_id       = op;
    bus.rs_reg_value_f_id = rs;
    bus.rt_reg_value_f_id = rt;
    bus.i_data_f_id       = imm;
    bus.rd_add_value_f_id = rd;
    bus.pc4_in_f_id       = pc4;
    bus.pc_in_f_id        = pc4 - 32'd4;
    bus.branch_f_id       = (op >= 6'd14 && op <= 6'd16);
    bus.mem_read_f_id     = mr;
    bus.mem_write_f_id    = mw;
    bus.mem_to_reg_f_id   = mtr;
  endtask

  task automatic test_reset();
    drive(6'd4, 32'd6, 32'd7, 32'd0, 5'd4, 32'd0, 1'b0, 1'b0, 1'b0);
    tick();
    #1;
    tests++; if (bus.stall_2_id !== 1'b0) begin fails++; $display("FAIL reset_stall got %b want 0", bus.stall_2_id); end
    tests++; if (bus.alu_result_2_mem !== 32'd0) begin fails++; $display("FAIL reset_alu got %h want 0", bus.alu_result_2_mem); end
    tests++; if ({bus.reg_write_2_mem, bus.mem_read_2_mem, bus.mem_write_2_mem, bus.mem_to_reg_2_mem,
                 bus.branch_taken_2_if, bus.halt_2_mem} !== 6'b0) begin
      fails++; $display("FAIL reset_ctrl got nonzero controls want 0"); end
    drive(6'd0, 32'd0, 32'd0, 32'd0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    tick();
    reset = 1'b0;
  endtask

  task automatic test_add();
    drive(6'd0, 32'd5, 32'd7, 32'd0, 5'd3, 32'd0, 1'b0, 1'b0, 1'b0);
    #1;
    tests++; if (bus.stall_2_id !== 1'b0) begin fails++; $display("FAIL add_stall got %b want 0", bus.stall_2_id); end
    tick();
    tests++; if (bus.alu_result_2_mem !== 32'd12) begin fails++; $display("FAIL add_alu got %h want 0000000c", bus.alu_result_2_mem); end
    tests++; if (bus.rd_add_2_mem !== 5'd3 || bus.reg_write_2_mem !== 1'b1) begin
      fails++; $display("FAIL add_wb got rd=%0d rw=%b want rd=3 rw=1", bus.rd_add_2_mem, bus.reg_write_2_mem); end
    drive(6'd3, 32'd0, 32'd0, 32'hFFFF_FFFF, 5'd2, 32'd0, 1'b0, 1'b0, 1'b0);
    tick();
    tests++; if (bus.alu_result_2_mem !== 32'd1) begin fails++; $display("FAIL subi_alu got %h want 00000001", bus.alu_result_2_mem); end
    drive(6'd1, 32'd1, 32'd0, 32'd2, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    tick();
    tests++; if (bus.alu_result_2_mem !== 32'd3 || bus.reg_write_2_mem !== 1'b0) begin
      fails++; $display("FAIL addi_rd0 got alu=%h rw=%b want alu=3 rw=0", bus.alu_result_2_mem, bus.reg_write_2_mem); end
  endtask

  task automatic test_logic();
    drive(6'd7, 32'h0000_00F0, 32'd0, 32'h0000_000F, 5'd1, 32'd0, 1'b0, 1'b0, 1'b0);
    tick();
    tests++; if (bus.alu_result_2_mem !== 32'h0000_00FF) begin fails++; $display("FAIL ori got %h want 000000ff", bus.alu_result_2_mem); end
    drive(6'd10, 32'h0000_00FF, 32'h0000_000F, 32'h1234_5678, 5'd1, 32'd0, 1'b0, 1'b0, 1'b0);
    tick();
    tests++; if (bus.alu_result_2_mem !== 32'h0000_00F0) begin fails++; $display("FAIL xor got %h want 000000f0", bus.alu_result_2_mem); end
    drive(6'd8, 32'hF0F0_1234, 32'h0FF0_00FF, 32'd0, 5'd1, 32'd0, 1'b0, 1'b0, 1'b0);
    tick();
    tests++; if (bus.alu_result_2_mem !== 32'h00F0_0034) begin fails++; $display("FAIL and got %h want 00f00034", bus.alu_result_2_mem); end
    drive(6'd2, 32'd3, 32'd5, 32'd0, 5'd1, 32'd0, 1'b0, 1'b0, 1'b0);
    tick();
    tests++; if (bus.alu_result_2_mem !== 32'hFFFF_FFFE) begin fails++; $display("FAIL sub_wrap got %h want fffffffe", bus.alu_result_2_mem); end
  endtask

  task automatic test_mul();
    int stall_cnt = 0;
    bit bubble_bad = 0;
    drive(6'd4, 32'd6, 32'd7, 32'd0, 5'd4, 32'd0, 1'b0, 1'b0, 1'b0);
    #1;
    for (int i = 0; i < 10 && bus.stall_2_id === 1'b1; i++) begin
      stall_cnt++;
      tick();
      if (bus.reg_write_2_mem !== 1'b0 || bus.alu_result_2_mem !== 32'd0) bubble_bad = 1;
    end
    tests++; if (stall_cnt != 3) begin fails++; $display("FAIL mul_stall_cycles got %0d want 3", stall_cnt); end
    tests++; if (bubble_bad) begin fails++; $display("FAIL mul_bubbles got non-bubble want bubble"); end
    tick();
    tests++; if (bus.alu_result_2_mem !== 32'd42 || bus.reg_write_2_mem !== 1'b1 || bus.rd_add_2_mem !== 5'd4) begin
      fails++; $display("FAIL mul_result got alu=%h rw=%b rd=%0d want 2a 1 4",
                        bus.alu_result_2_mem, bus.reg_write_2_mem, bus.rd_add_2_mem); end
    drive(6'd0, 32'd1, 32'd2, 32'd0, 5'd5, 32'd0, 1'b0, 1'b0, 1'b0);
    tick();
    tests++; if (bus.alu_result_2_mem !== 32'd3 || bus.rd_add_2_mem !== 5'd5) begin
      fails++; $display("FAIL add_after_mul got alu=%h rd=%0d want 3 5", bus.alu_result_2_mem, bus.rd_add_2_mem); end
  endtask

  task automatic test_back_to_back();
    drive(6'd5, 32'd3, 32'd100, 32'd5, 5'd6, 32'd0, 1'b0, 1'b0, 1'b0);
    repeat (4) tick();
    tests++; if (bus.alu_result_2_mem !== 32'd15) begin fails++; $display("FAIL muli_result got %h want 0000000f", bus.alu_result_2_mem); end
    drive(6'd4, 32'hFFFF_FFFF, 32'd2, 32'd9, 5'd7, 32'd0, 1'b0, 1'b0, 1'b0);
    #1;
    tests++; if (bus.stall_2_id !== 1'b1) begin fails++; $display("FAIL b2b_stall got %b want 1", bus.stall_2_id); end
    repeat (3) tick();
    tests++; if (bus.stall_2_id !== 1'b0 || bus.alu_result_2_mem !== 32'd0) begin
      fails++; $display("FAIL b2b_last_cycle got stall=%b alu=%h want 0 0", bus.stall_2_id, bus.alu_result_2_mem); end
    tick();
    tests++; if (bus.alu_result_2_mem !== 32'hFFFF_FFFE || bus.rd_add_2_mem !== 5'd7) begin
      fails++; $display("FAIL b2b_result got alu=%h rd=%0d want fffffffe 7", bus.alu_result_2_mem, bus.rd_add_2_mem); end
  endtask

  task automatic test_branch();
    drive(6'd15, 32'd9, 32'd9, 32'd3, 5'd0, 32'h104, 1'b0, 1'b0, 1'b0);
    tick();
    tests++; if (bus.branch_taken_2_if !== 1'b1 || bus.branch_target_2_if !== 32'h110) begin
      fails++; $display("FAIL beq got taken=%b tgt=%h want 1 00000110", bus.branch_taken_2_if, bus.branch_target_2_if); end
    tests++; if (bus.reg_write_2_mem !== 1'b0) begin fails++; $display("FAIL beq_rw got %b want 0", bus.reg_write_2_mem); end
    drive(6'd14, 32'd1, 32'd0, 32'd3, 5'd0, 32'h104, 1'b0, 1'b0, 1'b0);
    tick();
    tests++; if (bus.branch_taken_2_if !== 1'b0 || bus.alu_result_2_mem !== 32'd0 || bus.reg_write_2_mem !== 1'b0) begin
      fails++; $display("FAIL bz_not_taken got taken=%b alu=%h rw=%b want 0 0 0",
                        bus.branch_taken_2_if, bus.alu_result_2_mem, bus.reg_write_2_mem); end
    drive(6'd14, 32'd0, 32'd5, 32'hFFFF_FFFE, 5'd0, 32'h4, 1'b0, 1'b0, 1'b0);
    tick();
    tests++; if (bus.branch_taken_2_if !== 1'b1 || bus.branch_target_2_if !== 32'hFFFF_FFFC) begin
      fails++; $display("FAIL bz_wrap got taken=%b tgt=%h want 1 fffffffc", bus.branch_taken_2_if, bus.branch_target_2_if); end
    drive(6'd16, 32'h2000, 32'd0, 32'd0, 5'd0, 32'h40, 1'b0, 1'b0, 1'b0);
    tick();
    tests++; if (bus.branch_taken_2_if !== 1'b1 || bus.branch_target_2_if !== 32'h2000) begin
      fails++; $display("FAIL jr got taken=%b tgt=%h want 1 00002000", bus.branch_taken_2_if, bus.branch_target_2_if); end
    drive(6'd0, 32'd1, 32'd1, 32'd0, 5'd1, 32'd0, 1'b0, 1'b0, 1'b0);
    tick();
    tests++; if (bus.branch_taken_2_if !== 1'b0) begin fails++; $display("FAIL branch_pulse got %b want 0", bus.branch_taken_2_if); end
  endtask

  task automatic test_mem();
    drive(6'd12, 32'h100, 32'd0, 32'hFFFF_FFFC, 5'd2, 32'd0, 1'b1, 1'b0, 1'b1);
    tick();
    tests++; if (bus.alu_result_2_mem !== 32'hFC || bus.reg_write_2_mem !== 1'b1 ||
                 bus.mem_read_2_mem !== 1'b1 || bus.mem_to_reg_2_mem !== 1'b1) begin
      fails++; $display("FAIL ldw got alu=%h rw=%b mr=%b mtr=%b want fc 1 1 1", bus.alu_result_2_mem,
                        bus.reg_write_2_mem, bus.mem_read_2_mem, bus.mem_to_reg_2_mem); end
    drive(6'd13, 32'h100, 32'hDEAD_BEEF, 32'hFFFF_FFFC, 5'd2, 32'd0, 1'b0, 1'b1, 1'b0);
    tick();
    tests++; if (bus.alu_result_2_mem !== 32'hFC || bus.store_data_2_mem !== 32'hDEAD_BEEF) begin
      fails++; $display("FAIL stw_data got alu=%h sd=%h want fc deadbeef", bus.alu_result_2_mem, bus.store_data_2_mem); end
    tests++; if (bus.mem_write_2_mem !== 1'b1 || bus.reg_write_2_mem !== 1'b0) begin
      fails++; $display("FAIL stw_ctrl got mw=%b rw=%b want 1 0", bus.mem_write_2_mem, bus.reg_write_2_mem); end
  endtask

  task automatic test_halt();
    drive(6'd17, 32'd0, 32'd0, 32'd0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    tick();
    tests++; if (bus.halt_2_mem !== 1'b1 || bus.alu_result_2_mem !== 32'd0) begin
      fails++; $display("FAIL halt got halt=%b alu=%h want 1 0", bus.halt_2_mem, bus.alu_result_2_mem); end
    drive(6'd0, 32'd5, 32'd7, 32'd0, 5'd3, 32'd0, 1'b0, 1'b0, 1'b0);
    repeat (2) tick();
    tests++; if (bus.alu_result_2_mem !== 32'd0 || bus.reg_write_2_mem !== 1'b0) begin
      fails++; $display("FAIL halted_bubble got alu=%h rw=%b want 0 0", bus.alu_result_2_mem, bus.reg_write_2_mem); end
    drive(6'd4, 32'd6, 32'd7, 32'd0, 5'd4, 32'd0, 1'b0, 1'b0, 1'b0);
    #1;
    tests++; if (bus.stall_2_id !== 1'b0) begin fails++; $display("FAIL halted_stall got %b want 0", bus.stall_2_id); end
    tick();
    tests++; if (bus.alu_result_2_mem !== 32'd0 || bus.reg_write_2_mem !== 1'b0) begin
      fails++; $display("FAIL halted_mul got alu=%h rw=%b want 0 0", bus.alu_result_2_mem, bus.reg_write_2_mem); end
  endtask

  task automatic test_reset_mid_mul();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    drive(6'd4, 32'd6, 32'd7, 32'd0, 5'd4, 32'd0, 1'b0, 1'b0, 1'b0);
    repeat (2) tick();
    reset = 1'b1;
    #1;
    tests++; if (bus.stall_2_id !== 1'b0 || bus.alu_result_2_mem !== 32'd0 || bus.reg_write_2_mem !== 1'b0) begin
      fails++; $display("FAIL reset_mid_mul got stall=%b alu=%h rw=%b want 0 0 0",
                        bus.stall_2_id, bus.alu_result_2_mem, bus.reg_write_2_mem); end
    drive(6'd0, 32'd5, 32'd7, 32'd0, 5'd3, 32'd0, 1'b0, 1'b0, 1'b0);
    tick();
    reset = 1'b0;
    #1;
    tests++; if (bus.stall_2_id !== 1'b0) begin fails++; $display("FAIL post_reset_stall got %b want 0", bus.stall_2_id); end
    tick();
    tests++; if (bus.alu_result_2_mem !== 32'd12 || bus.reg_write_2_mem !== 1'b1) begin
      fails++; $display("FAIL post_reset_add got alu=%h rw=%b want c 1", bus.alu_result_2_mem, bus.reg_write_2_mem); end
  endtask

  initial begin
    drive(6'd0, 32'd0, 32'd0, 32'd0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    test_reset();
    test_add();
    test_logic();
    test_mul();
    test_back_to_back();
    test_branch();
    test_mem();
    test_halt();
    test_reset_mid_mul();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the five-stage pipeline. It sits between the decode stage's `*_2_ex` pipeline registers and the memory stage. It consumes the decoded opcode, operands, destination address and control bits. It performs ALU operations, branch/jump resolution and a multi-cycle multiply, and registers the results into the EX/MEM pipeline register. While a multiply is in progress it back-pressures decode with `stall_2_id`.

## Interface
Parameters:
- MUL_LAT, 3, multiply busy cycles after acceptance; legal range 1..15

Ports:
- Clock and reset: one clock; reset is asynchronous and active-high (`clk`, `reset`).
- clk  in  1  clock
- reset  in  1  async active-high reset
- opcode_f_id  in  6  decoded opcode
- rs_reg_value_f_id  in  32  rs operand
- rt_reg_value_f_id  in  32  rt operand; store data for STW
- rd_add_value_f_id  in  5  destination register address
- i_data_f_id  in  32  sign-extended immediate
- pc_in_f_id  in  32  instruction PC
- pc4_in_f_id  in  32  PC+4
- branch_f_id, mem_read_f_id, mem_to_reg_f_id, mem_write_f_id  in  1 each  control bits from decode
- stall_2_id  out  1  combinational; decode holds its `_2_ex` registers while high
- alu_result_2_mem  out  32  ALU/multiply result or memory address
- store_data_2_mem  out  32  registered rt value
- rd_add_2_mem  out  5  destination address
- reg_write_2_mem  out  1  write-back enable
- mem_read_2_mem, mem_write_2_mem, mem_to_reg_2_mem  out  1 each  registered controls
- branch_taken_2_if  out  1  redirect fetch
- branch_target_2_if  out  32  redirect address
- halt_2_mem  out  1  HALT reached memory stage

## Operation
- Opcodes:
  - 0/1 add/addi
  - 2/3 sub/subi
  - 4/5 mul/muli
  - 6/7 or/ori
  - 8/9 and/andi
  - 10/11 xor/xori
  - 12 LDW, 13 STW
  - 14 BZ, 15 BEQ, 16 JR
  - 17 HALT
- Operand selection: odd ALU opcodes (1–11) use op2 = i_data; even ALU opcodes (0–10) use op2 = rt.
- Arithmetic: all results are 32-bit modulo 2^32 with no overflow flag. Multiply returns the low 32 bits of rs*op2.
- Memory ops:
  - LDW/STW: alu_result = rs + i_data.
  - LDW: reg_write=1.
  - STW: reg_write=0; store_data = rt.
- Write-back: reg_write=1 for opcodes 0–12 only, and never when rd_add_value_f_id==0.
- Branch resolution:
  - BZ is taken when rs==0.
  - BEQ is taken when rs==rt.
  - JR is always taken.
  - BZ/BEQ target = pc4 + (i_data<<2), wrapping mod 2^32. JR target = rs.
- Bubbles: not-taken branches, HALT and unknown opcodes produce zero alu_result and all controls 0. HALT sets halt_2_mem=1.
- States:
  - IDLE: accept the input each cycle.
  - MUL: multiply busy.
  - HALTED: terminal.
- Transitions:
  - IDLE + mul/muli → MUL. Operands are latched and cnt loaded to MUL_LAT-1.
  - MUL with cnt>0 → MUL, decrementing cnt.
  - MUL with cnt==0 → IDLE; the product is loaded into EX/MEM.
  - IDLE + HALT → HALTED.
  - HALTED → HALTED until reset; all inputs are ignored and bubbles are emitted.
- stall_2_id = (IDLE && opcode is mul/muli) || (MUL && cnt!=0). It is low in HALTED.
- While stall_2_id is high, EX/MEM loads a bubble. The operand latch, not the inputs, drives the product.

## Timing
- Reset: every output is 0, state=IDLE, cnt=0, stall_2_id=0. This also applies to reset asserted mid-multiply or in HALTED; no partial result is ever emitted.
- Non-multiply ops: 1 cycle. Inputs present in cycle N appear on `*_2_mem` and `*_2_if` after edge N+1.
- branch_taken_2_if is a 1-cycle pulse aligned with the EX/MEM update. Flushing younger instructions is the fetch/decode responsibility.
- Multiply occupancy is MUL_LAT+1 cycles:
  - stall_2_id is high for MUL_LAT cycles.
  - The result is registered at the edge ending the cnt==0 cycle.
  - The next instruction is accepted in the following cycle.
- Back-to-back multiplies: the second is seen in IDLE the cycle after completion and restarts the sequence with no extra gap.

## Structure
- Shared package (alongside `mem_t` in struct.sv): `opcode_t` enum with the 18 opcodes above; `ex_state_t` {IDLE, MUL, HALTED}.
- Sub-module `ex_mul`: operand latch, cnt, done pulse, 32-bit low product.
- ALU and branch compare stay in `ex_stage` as `always_comb`; the EX/MEM register uses `always_ff` with async reset.

## Test plan
- add, rs=5, rt=7, rd=3 → alu_result=12, rd_add=3, reg_write=1 after one edge; stall_2_id stays 0.
- subi, rs=0, i_data=0xFFFFFFFF → alu_result=0x00000001. addi with rd=0 → reg_write=0.
- mul, rs=6, rt=7, MUL_LAT=3 → stall_2_id high 3 cycles, bubbles, then alu_result=42 with reg_write=1. An add held behind it issues on the next edge.
- BEQ, rs=rt=9, pc4=0x104, i_data=3 → branch_taken=1, target=0x110 for one cycle. BZ with rs=1 → bubble, no redirect. JR with rs=0x2000 → target 0x2000.
- LDW/STW, rs=0x100, i_data=0xFFFFFFFC → address 0xFC. STW drives store_data=rt and mem_write=1.
- HALT followed by add → halt_2_mem=1, then permanent bubbles. Reset during MUL cnt=1 → all outputs 0, stall low, and a subsequent add completes normally.
